// File: rtl/ddrdll_ctrl_pkg.sv
// Shared types and default parameter values for the DDRDLL code controller.
package ddrdll_ctrl_pkg;

    typedef enum logic [2:0] {
        LOCK_WAIT = 3'd0,
        IDLE      = 3'd1,
        FREEZE    = 3'd2,
        SAMPLE    = 3'd3,
        RELEASE   = 3'd4
    } state_e;

    localparam int DEF_CODE_W       = 9;
    localparam int DEF_LOCK_FILT    = 16;
    localparam int DEF_UPD_INTERVAL = 1024;
    localparam int DEF_FREEZE_SETUP = 4;
    localparam int DEF_MAX_STEP     = 8;

endpackage

// File: rtl/ddrdll_lock_filt.sv
// Lock qualifier: counts consecutive high samples of the DLL lock, saturating at LOCK_FILT.
module ddrdll_lock_filt
    import ddrdll_ctrl_pkg::*;
#(
    parameter int LOCK_FILT = DEF_LOCK_FILT
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic lock_i,
    output logic qual_pulse_o,
    output logic qual_lvl_o
);

    localparam int CNT_W = $clog2(LOCK_FILT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_FILT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // Run-length count of lock; any low sample restarts qualification.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!lock_i) begin
            cnt_d = {CNT_W{1'b0}};
            lvl_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
            lvl_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            lvl_d = (cnt_q == CNT_LAST);
        end
    end

    // Counter and level registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= {CNT_W{1'b0}};
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign qual_pulse_o = lock_i & (cnt_q == CNT_LAST);
    assign qual_lvl_o   = lvl_q;

endmodule

// File: rtl/ddrdll_code_ctrl.sv
// DDRDLL code controller: lock qualify, periodic freeze/sample, held code to delay lines.
// Optional step-limit check on sampled codes is enabled by DDRDLL_CODE_STEP_CHECK_EN.
module ddrdll_code_ctrl
    import ddrdll_ctrl_pkg::*;
#(
    parameter int CODE_W       = DEF_CODE_W,
    parameter int LOCK_FILT    = DEF_LOCK_FILT,
    parameter int UPD_INTERVAL = DEF_UPD_INTERVAL,
    parameter int FREEZE_SETUP = DEF_FREEZE_SETUP,
    parameter int MAX_STEP     = DEF_MAX_STEP
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              dll_lock_i,
    input  logic [CODE_W-1:0] dll_code_i,
    input  logic              upd_req_i,
    input  logic              bus_idle_i,
    output logic              freeze_o,
    output logic              uddcntln_o,
    output logic [CODE_W-1:0] code_o,
    output logic              code_valid_o,
    output logic              locked_o,
    output logic              upd_done_o,
    output logic              step_err_o
);

    localparam int TMR_W  = $clog2(UPD_INTERVAL + 1);
    localparam int FCNT_W = $clog2(FREEZE_SETUP + 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(UPD_INTERVAL);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(UPD_INTERVAL - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FREEZE_SETUP - 1);

    if (CODE_W < 1 || LOCK_FILT < 1 || UPD_INTERVAL < 1 || FREEZE_SETUP < 1 || MAX_STEP < 0) begin : g_bad_param
        $error("ddrdll_code_ctrl: illegal parameter value");
    end

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                pend_q, pend_d;
    logic                freeze_q, freeze_d;
    logic                udd_q, udd_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                qual_pulse_s, qual_lvl_s;
    logic                lock_lost_s, expire_s, pend_s, go_s, accept_s;

    ddrdll_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_lock_filt (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .lock_i       (dll_lock_i),
        .qual_pulse_o (qual_pulse_s),
        .qual_lvl_o   (qual_lvl_s)
    );

    assign lock_lost_s = (state_q != LOCK_WAIT) & ~dll_lock_i;
    // Timer counts IDLE cycles already spent, so the current cycle completes the interval.
    assign expire_s    = (tmr_q >= TMR_LAST);
    assign pend_s      = pend_q | expire_s | upd_req_i;
    assign go_s        = pend_s & bus_idle_i;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= LOCK_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic, including the freeze setup counter.
    always_comb begin
        state_d = state_q;
        fcnt_d  = {FCNT_W{1'b0}};
        if (lock_lost_s) begin
            state_d = LOCK_WAIT;
        end else begin
            case (state_q)
                LOCK_WAIT: if (qual_pulse_s) state_d = IDLE;    else state_d = LOCK_WAIT;
                IDLE:      if (go_s)         state_d = FREEZE;  else state_d = IDLE;
                FREEZE: begin
                    if (fcnt_q == FCNT_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = FREEZE;
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                    end
                end
                SAMPLE:    state_d = RELEASE;
                RELEASE:   state_d = IDLE;
                default:   state_d = LOCK_WAIT;
            endcase
        end
    end

    // Update scheduling: interval timer and pending request.
    always_comb begin
        tmr_d  = {TMR_W{1'b0}};
        pend_d = pend_q;
        if (lock_lost_s) begin
            pend_d = 1'b0;
        end else begin
            case (state_q)
                LOCK_WAIT: pend_d = qual_pulse_s;
                IDLE: begin
                    if (go_s) begin
                        pend_d = 1'b0;
                    end else begin
                        pend_d = pend_s;
                        if (tmr_q == TMR_MAX) tmr_d = tmr_q; else tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                FREEZE, SAMPLE, RELEASE: pend_d = pend_q | upd_req_i;
                default: pend_d = 1'b0;
            endcase
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_comb begin
        freeze_d = 1'b0;
        udd_d    = 1'b1;
        done_d   = 1'b0;
        valid_d  = valid_q;
        code_d   = code_q;
        case (state_d)
            LOCK_WAIT: valid_d = 1'b0;
            IDLE:      valid_d = valid_q;
            FREEZE:    freeze_d = 1'b1;
            SAMPLE: begin
                freeze_d = 1'b1;
                udd_d    = 1'b0;
            end
            RELEASE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                if (accept_s) code_d = dll_code_i; else code_d = code_q;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tmr_q    <= {TMR_W{1'b0}};
            fcnt_q   <= {FCNT_W{1'b0}};
            pend_q   <= 1'b0;
            freeze_q <= 1'b0;
            udd_q    <= 1'b1;
            code_q   <= {CODE_W{1'b0}};
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            fcnt_q   <= fcnt_d;
            pend_q   <= pend_d;
            freeze_q <= freeze_d;
            udd_q    <= udd_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

`ifdef DDRDLL_CODE_STEP_CHECK_EN
    localparam int DIFF_W = CODE_W + 1;

    logic [DIFF_W-1:0] diff_s;
    logic              first_q, first_d;
    logic              step_err_q, step_err_d;

    assign diff_s   = (dll_code_i >= code_q) ? ({1'b0, dll_code_i} - {1'b0, code_q})
                                             : ({1'b0, code_q} - {1'b0, dll_code_i});
    assign accept_s = first_q | (diff_s <= DIFF_W'(MAX_STEP));

    // The first sample after any (re)lock is trusted unconditionally.
    always_comb begin
        first_d    = first_q;
        step_err_d = step_err_q;
        if (state_d == LOCK_WAIT) begin
            first_d = 1'b1;
        end else if (state_d == RELEASE) begin
            first_d    = 1'b0;
            step_err_d = step_err_q | ~accept_s;
        end else begin
            first_d    = first_q;
            step_err_d = step_err_q;
        end
    end

    // Step-check registers; the error flag is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            first_q    <= 1'b1;
            step_err_q <= 1'b0;
        end else begin
            first_q    <= first_d;
            step_err_q <= step_err_d;
        end
    end

    assign step_err_o = step_err_q;
`else
    assign accept_s   = 1'b1;
    assign step_err_o = 1'b0;
`endif

    assign freeze_o     = freeze_q;
    assign uddcntln_o   = udd_q;
    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign locked_o     = qual_lvl_s;
    assign upd_done_o   = done_q;

endmodule

// File: doc/ddrdll_code_ctrl.md
# ddrdll_code_ctrl

Soft controller directly downstream of the LIFCL `DDRDLL_CORE` hard block. It qualifies the DLL lock, then periodically freezes the DLL and samples its delay code. It drives the `UDDCNTLN` update strobe and presents a held, glitch-free code to the DLLDEL/DQSBUF delay lines. Updates happen only while the memory controller reports the bus idle.

## Interface
- `CODE_W`, 9: width of DDRDLL delay code.
- `LOCK_FILT`, 16: consecutive cycles of `dll_lock_i` high required to declare lock (≥1).
- `UPD_INTERVAL`, 1024: cycles between periodic updates (≥1).
- `FREEZE_SETUP`, 4: cycles `freeze_o` is held before the code is sampled (≥1).
- `MAX_STEP`, 8: largest accepted code change per update (check feature only).
- `clk_i`, in, 1: single clock, same domain as the DDRDLL CODE outputs.
- `rstn_i`, in, 1: **synchronous, active-low** reset.
- `dll_lock_i`, in, 1: DDRDLL LOCK.
- `dll_code_i`, in, CODE_W: DDRDLL CODE.
- `upd_req_i`, in, 1: manual update request, single-cycle pulse.
- `bus_idle_i`, in, 1: high when a freeze/update is permitted.
- `freeze_o`, out, 1: to DDRDLL FREEZE.
- `uddcntln_o`, out, 1: to DDRDLL UDDCNTLN; active-low update strobe.
- `code_o`, out, CODE_W: held code to the delay lines.
- `code_valid_o`, out, 1: `code_o` reflects a sample taken under the current lock.
- `locked_o`, out, 1: filtered lock.
- `upd_done_o`, out, 1: one-cycle pulse per completed update.
- `step_err_o`, out, 1: sticky step-violation flag.

## Operation
- States: `LOCK_WAIT`, `IDLE`, `FREEZE`, `SAMPLE`, `RELEASE`. Reset state is `LOCK_WAIT`.
- `LOCK_WAIT`: the filter counter increments while `dll_lock_i`=1 and clears to 0 whenever `dll_lock_i`=0. On reaching `LOCK_FILT`, the FSM goes to `IDLE`, sets `locked_o`, and sets the pending flag so the first update is forced.
- `IDLE`: the interval timer counts up and saturates at `UPD_INTERVAL`; on reaching it, pending is set. `upd_req_i` also sets pending. When pending=1 and `bus_idle_i`=1, the FSM goes to `FREEZE`.
- `FREEZE`: `freeze_o`=1 for `FREEZE_SETUP` cycles, then `SAMPLE`.
- `SAMPLE`: one cycle. `freeze_o`=1, `uddcntln_o`=0, and `dll_code_i` is captured at the end of the cycle.
- `RELEASE`: one cycle, then `IDLE`. During it: `freeze_o`=0, `uddcntln_o`=1, `code_o` shows the captured value, `code_valid_o`=1, `upd_done_o`=1. Pending and the timer clear.
- `upd_req_i` arriving in `FREEZE`/`SAMPLE`/`RELEASE` re-sets pending after the clear and is serviced on the next `IDLE` pass.
- Timer expiry and `upd_req_i` in the same cycle produce one update.
- `bus_idle_i` is sampled only in `IDLE`. Deassertion after `FREEZE` is entered does not abort the update.
- Lock loss (`dll_lock_i`=0) in any state other than `LOCK_WAIT`:
  - next state `LOCK_WAIT`;
  - `freeze_o`=0, `uddcntln_o`=1, `locked_o`=0, `code_valid_o`=0;
  - `code_o` holds its last value; no `upd_done_o`.
- Arithmetic: the timer is `$clog2(UPD_INTERVAL+1)` bits and the lock counter is `$clog2(LOCK_FILT+1)` bits, both saturating. The step difference is computed unsigned in CODE_W+1 bits as an absolute value.

## Timing
- Reset values: `freeze_o`=0, `uddcntln_o`=1, `code_o`=0, `code_valid_o`=0, `locked_o`=0, `upd_done_o`=0, `step_err_o`=0. Counters 0, pending 0.
- Lock qualification: `locked_o` rises exactly `LOCK_FILT` cycles after `dll_lock_i` is first seen high, given an unbroken high run.
- Update: if the FSM leaves `IDLE` at edge T, then:
  - `freeze_o` is high for `FREEZE_SETUP`+1 cycles starting T+1;
  - `uddcntln_o` is low in the last of those cycles;
  - `code_o` changes and `upd_done_o` pulses in the cycle `freeze_o` falls.
- Periodic spacing: consecutive updates are ≥ `UPD_INTERVAL`+`FREEZE_SETUP`+2 cycles apart when not forced by `upd_req_i`.
- All outputs are registered.

## Configuration
- Macro `DDRDLL_CODE_STEP_CHECK_EN`.
- Defined: on the first update after each lock, the sample is always accepted. On later updates, a sample differing from the current `code_o` by more than `MAX_STEP` is discarded: `code_o` is unchanged, `upd_done_o` still pulses, `step_err_o` sets, and the FSM proceeds normally. `step_err_o` clears only on reset.
- Undefined: every sample is accepted and `step_err_o` is tied 0. The port list is identical in both builds.

## Structure
- Package `ddrdll_ctrl_pkg`: FSM state enum and default parameter constants.
- One sub-module, `ddrdll_lock_filt`: saturating lock-qualification counter producing the lock-qualified pulse and level.

## Test plan
- Reset → after `rstn_i` rises, lock high 16 cycles → `locked_o` at cycle 16. Then with `bus_idle_i`=1: `freeze_o` high 5 cycles, `uddcntln_o` low 1 cycle, `code_o`=`dll_code_i`, one `upd_done_o`.
- Locked and idle, code 0x40 → next update exactly 1024+6 cycles after the previous one. A code change to 0x44 appears on `code_o` only in the `RELEASE` cycle.
- `upd_req_i` with `bus_idle_i`=0 for 50 cycles → no freeze. Freeze starts the cycle after `bus_idle_i`=1; a second `upd_req_i` during `FREEZE` gives a second update right after.
- Drop `dll_lock_i` during `SAMPLE` → `freeze_o`=0, `locked_o`=0, `code_valid_o`=0 next cycle, `code_o` unchanged. Relock gives a forced update.
- With `DDRDLL_CODE_STEP_CHECK_EN`: `code_o`=0x40, sample 0x50 → `code_o` stays 0x40, `step_err_o`=1, `upd_done_o` pulses. Sample 0x47 → accepted.
- Assert `rstn_i`=0 mid-`FREEZE` → all outputs at reset values on the next edge.
